// File: rtl/chroma_bbox_tracker.sv
// Green-key bounding-box tracker on the VGA pixel stream; publishes one box per frame.
// Optional CHROMA_HIT_COUNT_EN adds a hit_count output with the number of qualified pixels per frame.
module chroma_bbox_tracker #(
   parameter int X_W       = 10,
   parameter int Y_W       = 10,
   parameter int COLOR_W   = 4,
   parameter int G_MARGIN  = 1,
   parameter int RUN_LEN   = 6,
   parameter int ROW_START = 0,
   parameter int ROW_END   = 479
) (
   input  logic               vga_pclk,
   input  logic               reset,
   input  logic               en,
   input  logic               den,
   input  logic [X_W-1:0]     x_pixel,
   input  logic [Y_W-1:0]     y_pixel,
   input  logic [COLOR_W-1:0] reg_r,
   input  logic [COLOR_W-1:0] reg_g,
   input  logic [COLOR_W-1:0] reg_b,
   output logic [X_W-1:0]     bbox_min_x,
   output logic [X_W-1:0]     bbox_max_x,
   output logic [Y_W-1:0]     bbox_min_y,
   output logic [Y_W-1:0]     bbox_max_y,
   output logic               obj_found,
   output logic               frame_done,
`ifdef CHROMA_HIT_COUNT_EN
   output logic [X_W+Y_W-1:0] hit_count,
`endif
   output logic [1:0]         dbg_state
);

   localparam int CW = COLOR_W + 2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SCAN    = 2'd1,
      S_PUBLISH = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   w_clear;
   logic   w_publish;

   logic [CW-1:0] w_r_ext, w_g_ext, w_b_ext;
   logic          w_hit;
   logic          w_ge_start, w_le_end;
   logic          w_scan, w_qhit, w_qual, w_row_chg;
   logic          w_sof, w_eof;
   logic [3:0]    w_cnt_base;
   logic [4:0]    w_cnt_inc;
   logic [X_W-1:0] w_x0;

   logic           r_den_d;
   logic [Y_W-1:0] r_y_d;
   logic [3:0]     r_run_cnt;
   logic [X_W-1:0] r_run_x0;

   logic [X_W-1:0] r_acc_min_x, r_acc_max_x;
   logic [Y_W-1:0] r_acc_min_y, r_acc_max_y;
   logic           r_acc_hit;
   logic [X_W-1:0] w_b_min_x, w_b_max_x;
   logic [Y_W-1:0] w_b_min_y, w_b_max_y;

   logic [X_W-1:0] r_bbox_min_x, r_bbox_max_x;
   logic [Y_W-1:0] r_bbox_min_y, r_bbox_max_y;
   logic           r_obj_found, r_frame_done;

   // Widened compare so r+G_MARGIN and b+G_MARGIN never wrap.
   assign w_r_ext = {2'b00, reg_r};
   assign w_g_ext = {2'b00, reg_g};
   assign w_b_ext = {2'b00, reg_b};
   assign w_hit   = (w_g_ext > (w_r_ext + CW'(G_MARGIN))) &&
                    (w_g_ext >= (w_b_ext + CW'(G_MARGIN))) &&
                    (reg_g != '0);

   if (ROW_START == 0) begin : g_rs_zero
      assign w_ge_start = 1'b1;
   end else begin : g_rs_cmp
      assign w_ge_start = (y_pixel >= Y_W'(ROW_START));
   end
   assign w_le_end = (y_pixel <= Y_W'(ROW_END));

   assign w_scan     = en && den && w_ge_start && w_le_end;
   assign w_qhit     = w_scan && w_hit;
   assign w_row_chg  = r_den_d && (y_pixel != r_y_d);
   assign w_cnt_base = w_row_chg ? 4'd0 : r_run_cnt;
   assign w_cnt_inc  = {1'b0, w_cnt_base} + 5'd1;
   assign w_qual     = w_qhit && (w_cnt_inc >= 5'(RUN_LEN));
   assign w_x0       = (w_cnt_base == 4'd0) ? x_pixel : r_run_x0;

   assign w_sof = den && !r_den_d && (y_pixel == '0);
   assign w_eof = r_den_d && !den && (r_y_d == Y_W'(ROW_END));

   always_ff @(posedge vga_pclk) begin
      if (reset) begin
         r_den_d <= 1'b0;
         r_y_d   <= '0;
      end else begin
         r_den_d <= den;
         if (den) r_y_d <= y_pixel;
      end
   end

   always_ff @(posedge vga_pclk) begin
      if (reset || !en) begin
         r_run_cnt <= 4'd0;
         r_run_x0  <= '0;
      end else if (w_qhit) begin
         r_run_cnt <= (w_cnt_inc >= 5'(RUN_LEN)) ? 4'(RUN_LEN) : w_cnt_inc[3:0];
         if (w_cnt_base == 4'd0) r_run_x0 <= x_pixel;
      end else begin
         r_run_cnt <= 4'd0;
      end
   end

   always_ff @(posedge vga_pclk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_publish   = 1'b0;
      if (!en) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_sof) begin
                  w_state_nxt = S_SCAN;
                  w_clear     = 1'b1;
               end
            end
            S_SCAN: begin
               if (w_sof)      w_clear     = 1'b1;
               else if (w_eof) w_state_nxt = S_PUBLISH;
            end
            S_PUBLISH: begin
               w_publish   = 1'b1;
               w_clear     = 1'b1;
               w_state_nxt = S_SCAN;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Clear first, then fold in the current pixel, so a qualified pixel on a clearing cycle opens the new frame.
   assign w_b_min_x = w_clear ? '1 : r_acc_min_x;
   assign w_b_max_x = w_clear ? '0 : r_acc_max_x;
   assign w_b_min_y = w_clear ? '1 : r_acc_min_y;
   assign w_b_max_y = w_clear ? '0 : r_acc_max_y;

   always_ff @(posedge vga_pclk) begin
      if (reset) begin
         r_acc_min_x <= '1;
         r_acc_max_x <= '0;
         r_acc_min_y <= '1;
         r_acc_max_y <= '0;
         r_acc_hit   <= 1'b0;
      end else begin
         r_acc_min_x <= (w_qual && (w_x0 < w_b_min_x))    ? w_x0    : w_b_min_x;
         r_acc_max_x <= (w_qual && (x_pixel > w_b_max_x)) ? x_pixel : w_b_max_x;
         r_acc_min_y <= (w_qual && (y_pixel < w_b_min_y)) ? y_pixel : w_b_min_y;
         r_acc_max_y <= (w_qual && (y_pixel > w_b_max_y)) ? y_pixel : w_b_max_y;
         r_acc_hit   <= w_qual || (!w_clear && r_acc_hit);
      end
   end

   always_ff @(posedge vga_pclk) begin
      if (reset) begin
         r_bbox_min_x <= '0;
         r_bbox_max_x <= '0;
         r_bbox_min_y <= '0;
         r_bbox_max_y <= '0;
         r_obj_found  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_publish;
         if (w_publish) begin
            r_bbox_min_x <= r_acc_hit ? r_acc_min_x : '0;
            r_bbox_max_x <= r_acc_hit ? r_acc_max_x : '0;
            r_bbox_min_y <= r_acc_hit ? r_acc_min_y : '0;
            r_bbox_max_y <= r_acc_hit ? r_acc_max_y : '0;
            r_obj_found  <= r_acc_hit;
         end
      end
   end

`ifdef CHROMA_HIT_COUNT_EN
   logic [X_W+Y_W-1:0] r_acc_cnt, w_b_cnt, r_hit_count;

   assign w_b_cnt = w_clear ? '0 : r_acc_cnt;

   always_ff @(posedge vga_pclk) begin
      if (reset) begin
         r_acc_cnt   <= '0;
         r_hit_count <= '0;
      end else begin
         r_acc_cnt <= (w_qual && (w_b_cnt != '1)) ? w_b_cnt + 1'b1 : w_b_cnt;
         if (w_publish) r_hit_count <= r_acc_cnt;
      end
   end

   assign hit_count = r_hit_count;
`endif

   assign bbox_min_x = r_bbox_min_x;
   assign bbox_max_x = r_bbox_max_x;
   assign bbox_min_y = r_bbox_min_y;
   assign bbox_max_y = r_bbox_max_y;
   assign obj_found  = r_obj_found;
   assign frame_done = r_frame_done;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_chroma_bbox_tracker.sv
// Directed bench for chroma_bbox_tracker: table of single-rectangle frames plus en/reset/truncation sequences.
// Rows without content are one pixel wide to keep full 480-row frames short.
`timescale 1ns/1ps
module tb_chroma_bbox_tracker;
  localparam int ROW_END = 479;

  logic       vga_pclk = 1'b0;
  logic       reset    = 1'b1;
  logic       en       = 1'b1;
  logic       den      = 1'b0;
  logic [9:0] x_pixel  = '0;
  logic [9:0] y_pixel  = '0;
  logic [3:0] reg_r = '0, reg_g = '0, reg_b = '0;
  logic [9:0] bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y;
  logic       obj_found, frame_done;
  logic [1:0] dbg_state;
`ifdef CHROMA_HIT_COUNT_EN
  logic [19:0] hit_count;
`endif

  chroma_bbox_tracker dut (
    .vga_pclk(vga_pclk), .reset(reset), .en(en), .den(den),
    .x_pixel(x_pixel), .y_pixel(y_pixel),
    .reg_r(reg_r), .reg_g(reg_g), .reg_b(reg_b),
    .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x),
    .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y),
    .obj_found(obj_found), .frame_done(frame_done),
`ifdef CHROMA_HIT_COUNT_EN
    .hit_count(hit_count),
`endif
    .dbg_state(dbg_state)
  );

  always #5 vga_pclk = ~vga_pclk;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  always @(negedge vga_pclk) if (frame_done === 1'b1) pulse_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input int f, input int x0, input int x1,
                          input int y0, input int y1);
    chk({name, ".found"}, int'(obj_found), f);
    chk({name, ".min_x"}, int'(bbox_min_x), x0);
    chk({name, ".max_x"}, int'(bbox_max_x), x1);
    chk({name, ".min_y"}, int'(bbox_min_y), y0);
    chk({name, ".max_y"}, int'(bbox_max_y), y1);
  endtask

  // One frame with a single colour rectangle; content rows span x=96..223, other rows are one black pixel.
  task automatic run_frame(input string name, input int x0, input int x1, input int y0, input int y1,
                           input int cr, input int cg, input int cb,
                           input int en_off, input int en_on, input int rst_row,
                           input int stop_row, input int exp_pub);
    int  pc0, lo, hi;
    bit  inr;
    pc0 = pulse_cnt;
    for (int y = 0; y <= ROW_END; y++) begin
      if (y == stop_row) break;
      if (y == rst_row) begin
        @(negedge vga_pclk); reset = 1'b1; den = 1'b0;
        @(posedge vga_pclk); #1;
        chk_outs({name, ".rst"}, 0, 0, 0, 0, 0);
        chk({name, ".rst.done"}, int'(frame_done), 0);
        chk({name, ".rst.state"}, int'(dbg_state), 0);
        @(negedge vga_pclk); reset = 1'b0;
      end
      inr = (y >= y0) && (y <= y1);
      lo  = inr ? 96 : 0;
      hi  = inr ? 223 : 0;
      for (int x = lo; x <= hi; x++) begin
        @(negedge vga_pclk);
        en      = !((y >= en_off) && (y < en_on));
        den     = 1'b1;
        x_pixel = 10'(x);
        y_pixel = 10'(y);
        inr     = (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
        reg_r   = inr ? 4'(cr) : 4'd0;
        reg_g   = inr ? 4'(cg) : 4'd0;
        reg_b   = inr ? 4'(cb) : 4'd0;
      end
      if (y == ROW_END) begin
        @(negedge vga_pclk); den = 1'b0; reg_r = '0; reg_g = '0; reg_b = '0;
        @(posedge vga_pclk); #1;
        chk({name, ".done_early"}, int'(frame_done), 0);
        @(posedge vga_pclk); #1;
        chk({name, ".done_lat2"}, int'(frame_done), exp_pub);
      end else begin
        repeat (2) begin
          @(negedge vga_pclk); den = 1'b0; reg_r = '0; reg_g = '0; reg_b = '0;
        end
      end
    end
    repeat (6) @(negedge vga_pclk);
    chk({name, ".pulses"}, pulse_cnt - pc0, exp_pub);
  endtask

  typedef struct {
    int x0, x1, y0, y1;
    int cr, cg, cb;
    int e_found, e_minx, e_maxx, e_miny, e_maxy, e_cnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{100, 119, 50, 60, 0, 0, 0, 0,   0,   0,  0,  0,   0}; // all black
    vecs[1] = '{100, 119, 50, 60, 2, 9, 2, 1, 100, 119, 50, 60, 165}; // green block
    vecs[2] = '{200, 204, 30, 30, 2, 9, 2, 0,   0,   0,  0,  0,   0}; // 5-px run rejected
    vecs[3] = '{100, 119, 50, 60, 8, 9, 2, 0,   0,   0,  0,  0,   0}; // g == r+margin
    vecs[4] = '{100, 119, 50, 60, 2, 9, 8, 1, 100, 119, 50, 60, 165}; // g == b+margin
    vecs[5] = '{200, 205, 30, 30, 2, 9, 2, 1, 200, 205, 30, 30,   1}; // exactly RUN_LEN
    vecs[6] = '{218, 223, 40, 40, 2, 9, 2, 1, 218, 223, 40, 40,   1}; // run ends at den fall
    vecs[7] = '{100, 119, 50, 60, 2, 9, 9, 0,   0,   0,  0,  0,   0}; // g < b+margin
    vecs[8] = '{100, 109, 50, 59, 2, 9, 2, 1, 100, 109, 50, 59,  50}; // 10x10 block

    repeat (3) @(posedge vga_pclk);
    #1;
    chk_outs("reset", 0, 0, 0, 0, 0);
    chk("reset.done", int'(frame_done), 0);
    chk("reset.state", int'(dbg_state), 0);
`ifdef CHROMA_HIT_COUNT_EN
    chk("reset.count", int'(hit_count), 0);
`endif
    @(negedge vga_pclk); reset = 1'b0;
    repeat (4) @(negedge vga_pclk);

    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      run_frame(nm, vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1,
                vecs[i].cr, vecs[i].cg, vecs[i].cb, 9999, 9999, 9999, 9999, 1);
      chk_outs(nm, vecs[i].e_found, vecs[i].e_minx, vecs[i].e_maxx, vecs[i].e_miny, vecs[i].e_maxy);
      chk({nm, ".state"}, int'(dbg_state), 1);
`ifdef CHROMA_HIT_COUNT_EN
      chk({nm, ".count"}, int'(hit_count), vecs[i].e_cnt);
`endif
    end

    // en low on rows 100..299: no publish this frame, previous box held.
    run_frame("en_gap", 130, 149, 310, 320, 2, 9, 2, 100, 300, 9999, 9999, 0);
    chk_outs("en_gap.hold", 1, 100, 109, 50, 59);
`ifdef CHROMA_HIT_COUNT_EN
    chk("en_gap.count", int'(hit_count), 50);
`endif
    run_frame("after_en", 130, 149, 310, 320, 2, 9, 2, 9999, 9999, 9999, 9999, 1);
    chk_outs("after_en", 1, 130, 149, 310, 320);
`ifdef CHROMA_HIT_COUNT_EN
    chk("after_en.count", int'(hit_count), 165);
`endif

    // Reset on row 200: outputs cleared, the rest of that frame is not published.
    run_frame("mid_rst", 100, 119, 250, 260, 2, 9, 2, 9999, 9999, 200, 9999, 0);
    chk_outs("mid_rst.after", 0, 0, 0, 0, 0);
    run_frame("after_rst", 100, 119, 250, 260, 2, 9, 2, 9999, 9999, 9999, 9999, 1);
    chk_outs("after_rst", 1, 100, 119, 250, 260);

    // Truncated frame with green, then a black frame: the re-SOF must discard the green.
    run_frame("trunc", 100, 119, 50, 60, 2, 9, 2, 9999, 9999, 9999, 100, 0);
    run_frame("after_trunc", 100, 119, 50, 60, 0, 0, 0, 9999, 9999, 9999, 9999, 1);
    chk_outs("after_trunc", 0, 0, 0, 0, 0);
`ifdef CHROMA_HIT_COUNT_EN
    chk("after_trunc.count", int'(hit_count), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
